// File: rtl/display_pkg.sv
// Glyph table, segment bit order and index-width helper for the seven-segment display driver.
// Codes are active-low, packed {a,b,c,d,e,f,g,dp} from bit7 down to bit0.
package display_pkg;

    localparam int BIT_A  = 7;
    localparam int BIT_B  = 6;
    localparam int BIT_C  = 5;
    localparam int BIT_D  = 4;
    localparam int BIT_E  = 3;
    localparam int BIT_F  = 2;
    localparam int BIT_G  = 1;
    localparam int BIT_DP = 0;

    localparam logic [7:0] SEG_0 = 8'h03;
    localparam logic [7:0] SEG_1 = 8'h9F;
    localparam logic [7:0] SEG_2 = 8'h25;
    localparam logic [7:0] SEG_3 = 8'h0D;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h49;
    localparam logic [7:0] SEG_6 = 8'h41;
    localparam logic [7:0] SEG_7 = 8'h1F;
    localparam logic [7:0] SEG_8 = 8'h01;
    localparam logic [7:0] SEG_9 = 8'h09;
    localparam logic [7:0] SEG_A = 8'h11;
    localparam logic [7:0] SEG_B = 8'hC1;
    localparam logic [7:0] SEG_C = 8'h63;
    localparam logic [7:0] SEG_D = 8'h85;
    localparam logic [7:0] SEG_E = 8'h61;
    localparam logic [7:0] SEG_F = 8'h71;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_GUION = 8'hFD;

    // Never returns less than 1 so single-entry counters still get a real bit.
    function automatic int clog2(input int valor);
        int w;
        w = 1;
        while ((1 << w) < valor)
            w++;
        return w;
    endfunction

endpackage

// File: rtl/decodificador_7seg.sv
// Nibble to active-low seven-segment code, with hex/dash selection, blanking and decimal point.
// Purely combinational, no clock; no flow control.
module decodificador_7seg
    import display_pkg::*;
(
    input  logic [3:0] valor,
    input  logic       modo_hex,
    input  logic       blank,
    input  logic       dp,
    output logic [7:0] codigo
);

    always_comb begin
        codigo = SEG_BLANK;
        if (!blank) begin
            case (valor)
                4'h0: codigo = SEG_0;
                4'h1: codigo = SEG_1;
                4'h2: codigo = SEG_2;
                4'h3: codigo = SEG_3;
                4'h4: codigo = SEG_4;
                4'h5: codigo = SEG_5;
                4'h6: codigo = SEG_6;
                4'h7: codigo = SEG_7;
                4'h8: codigo = SEG_8;
                4'h9: codigo = SEG_9;
                4'hA: codigo = modo_hex ? SEG_A : SEG_GUION;
                4'hB: codigo = modo_hex ? SEG_B : SEG_GUION;
                4'hC: codigo = modo_hex ? SEG_C : SEG_GUION;
                4'hD: codigo = modo_hex ? SEG_D : SEG_GUION;
                4'hE: codigo = modo_hex ? SEG_E : SEG_GUION;
                4'hF: codigo = modo_hex ? SEG_F : SEG_GUION;
            endcase
        end
        // The point stays lit even on a suppressed digit.
        if (dp)
            codigo[BIT_DP] = 1'b0;
    end

endmodule

// File: rtl/multiplexor_display.sv
// Time-multiplexed N-digit common-anode driver with frame-latched data and anti-ghost blanking.
// Outputs registered one cycle behind the scan counters; free-running, no backpressure.
module multiplexor_display
    import display_pkg::*;
#(
    parameter int N_DIGITOS    = 4,
    parameter int DIV_REFRESCO = 100000,
    parameter int BLANK        = 1000
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic [4*N_DIGITOS-1:0]   datos,
    input  logic [N_DIGITOS-1:0]     puntos,
    input  logic [N_DIGITOS-1:0]     habilitar,
    input  logic                     modo_hex,
    input  logic                     supr_ceros,
    output logic [7:0]               segmentos,
    output logic [N_DIGITOS-1:0]     anodos,
    output logic                     fin_trama
);

    localparam int PW = clog2(DIV_REFRESCO);
    localparam int IW = clog2(N_DIGITOS);
    localparam logic [PW-1:0] P_FIN   = PW'(DIV_REFRESCO - 1);
    localparam logic [PW-1:0] P_BLANK = PW'(BLANK);
    localparam logic [IW-1:0] I_FIN   = IW'(N_DIGITOS - 1);

    logic [PW-1:0]                p;
    logic [IW-1:0]                i;
    logic [N_DIGITOS-1:0][3:0]    sh_datos;
    logic [N_DIGITOS-1:0]         sh_puntos;
    logic                         sh_hex;
    logic                         sh_supr;

    logic [N_DIGITOS-1:0]         suprimir;
    logic                         ceros_arriba;
    logic [N_DIGITOS-1:0]         sel_n;
    logic [7:0]                   glifo;
    logic                         fin_slot;
    logic                         fin_frame;
    logic                         oscuro;

    assign fin_slot  = (p == P_FIN);
    assign fin_frame = fin_slot && (i == I_FIN);
    assign oscuro    = (p < P_BLANK) || !habilitar[i];

    // Walk from the most significant digit down; a digit is blank while every digit above is zero.
    always_comb begin
        suprimir     = '0;
        ceros_arriba = 1'b1;
        for (int k = N_DIGITOS - 1; k >= 0; k--) begin
            ceros_arriba = ceros_arriba && (sh_datos[k] == 4'd0);
            suprimir[k]  = sh_supr && ceros_arriba && (k != 0);
        end
    end

    always_comb begin
        sel_n = '1;
        for (int k = 0; k < N_DIGITOS; k++)
            sel_n[k] = (i != IW'(k));
    end

    decodificador_7seg u_dec (
        .valor    (sh_datos[i]),
        .modo_hex (sh_hex),
        .blank    (suprimir[i]),
        .dp       (sh_puntos[i]),
        .codigo   (glifo)
    );

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            p         <= '0;
            i         <= '0;
            sh_datos  <= '0;
            sh_puntos <= '0;
            sh_hex    <= 1'b0;
            sh_supr   <= 1'b0;
            segmentos <= SEG_BLANK;
            anodos    <= '1;
            fin_trama <= 1'b0;
        end else begin
            fin_trama <= 1'b0;
            if (fin_slot) begin
                p <= '0;
                i <= (i == I_FIN) ? '0 : i + 1'b1;
            end else begin
                p <= p + 1'b1;
            end

            if (fin_frame) begin
                sh_datos  <= datos;
                sh_puntos <= puntos;
                sh_hex    <= modo_hex;
                sh_supr   <= supr_ceros;
                fin_trama <= 1'b1;
            end

            if (oscuro) begin
                anodos    <= '1;
                segmentos <= SEG_BLANK;
            end else begin
                anodos    <= sel_n;
                segmentos <= glifo;
            end
        end
    end

endmodule

// File: tb/tb_multiplexor_display.sv
// Scoreboard bench for multiplexor_display with DIV_REFRESCO=8, BLANK=2, N_DIGITOS=4.
// Stimulus queues hand-computed per-cycle expectations; a negedge monitor pops and compares them.
module tb_multiplexor_display;

    logic        CLK;
    logic        reset;
    logic [15:0] datos;
    logic [3:0]  puntos;
    logic [3:0]  habilitar;
    logic        modo_hex;
    logic        supr_ceros;
    logic [7:0]  segmentos;
    logic [3:0]  anodos;
    logic        fin_trama;

    multiplexor_display #(
        .N_DIGITOS    (4),
        .DIV_REFRESCO (8),
        .BLANK        (2)
    ) dut (
        .CLK        (CLK),
        .reset      (reset),
        .datos      (datos),
        .puntos     (puntos),
        .habilitar  (habilitar),
        .modo_hex   (modo_hex),
        .supr_ceros (supr_ceros),
        .segmentos  (segmentos),
        .anodos     (anodos),
        .fin_trama  (fin_trama)
    );

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [7:0] seg;
        logic       fin;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   ecnt  = 0;

    // Expected digit codes per frame, packed {d3,d2,d1,d0}.
    logic [31:0] glifos [10] = '{
        32'h03030303, 32'h9F250D99, 32'h11C10371, 32'hFDFD03FD, 32'hFFFE4903,
        32'hFFFFFF03, 32'h9F9F9F9F, 32'h25252525, 32'h25252525, 32'h25252525};
    logic [15:0] t_dat [10] = '{16'h0000, 16'h1234, 16'hAB0F, 16'hAB0F, 16'h0050,
                                16'h0000, 16'h1111, 16'h2222, 16'h2222, 16'h2222};
    bit          t_hex [10] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    bit          t_sup [10] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
    logic [3:0]  t_pts [10] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'b0100, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) ecnt <= ecnt + 1;

    task automatic push_one(input int c, input logic [3:0] an, input logic [7:0] seg, input logic fin);
        exp_t e;
        e.cyc = c; e.an = an; e.seg = seg; e.fin = fin;
        sb.push_back(e);
    endtask

    // Frame f of a scan starting after edge b covers edges b+32f+1 .. b+32f+32.
    task automatic push_frame(input int b, input int f, input logic [31:0] g,
                              input logic [3:0] hab, input int last_r);
        for (int r = 32 * f + 1; r <= 32 * f + 32 && r <= last_r; r++) begin
            int q;
            int d;
            q = (r - 1) % 8;
            d = ((r - 1) / 8) % 4;
            if (q < 2 || !hab[d])
                push_one(b + r, 4'hF, 8'hFF, (r % 32) == 0);
            else
                push_one(b + r, ~(4'b0001 << d), g[d*8 +: 8], (r % 32) == 0);
        end
    endtask

    task automatic wait_edge(input int n);
        do @(negedge CLK); while (ecnt < n);
    endtask

    always @(negedge CLK) begin
        while (sb.size() > 0 && sb[0].cyc < ecnt) begin
            total++;
            bad++;
            $display("FAIL missed cyc=%0d now=%0d", sb[0].cyc, ecnt);
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].cyc == ecnt) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            if (anodos !== e.an) begin
                bad++;
                $display("FAIL anodos cyc=%0d got=%b exp=%b", ecnt, anodos, e.an);
            end
            total++;
            if (segmentos !== e.seg) begin
                bad++;
                $display("FAIL segmentos cyc=%0d got=%h exp=%h", ecnt, segmentos, e.seg);
            end
            total++;
            if (fin_trama !== e.fin) begin
                bad++;
                $display("FAIL fin_trama cyc=%0d got=%b exp=%b", ecnt, fin_trama, e.fin);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cyc=%0d", ecnt);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int e_rst;
        reset      = 1'b0;
        datos      = 16'h0;
        puntos     = 4'h0;
        habilitar  = 4'hF;
        modo_hex   = 1'b0;
        supr_ceros = 1'b0;
        base       = 5;

        for (int c = 1; c <= base; c++)
            push_one(c, 4'hF, 8'hFF, 1'b0);
        push_frame(base, 0, glifos[0], 4'hF, 32);

        wait_edge(base);
        reset = 1'b1;

        // Inputs for frame f are applied during frame f-1, well away from its latch edge.
        for (int f = 1; f <= 9; f++) begin
            if (f > 1)
                wait_edge(base + 32 * (f - 1));
            datos      = t_dat[f];
            modo_hex   = t_hex[f];
            supr_ceros = t_sup[f];
            puntos     = t_pts[f];
            if (f == 9)
                push_frame(base, f, glifos[f], 4'hF, 308);
            else
                push_frame(base, f, glifos[f], (f == 8) ? 4'b1011 : 4'hF, 32 * f + 32);
            if (f == 6) begin
                wait_edge(base + 32 * 5 + 12);
            end
        end

        wait_edge(base + 256);
        habilitar = 4'b1011;
        wait_edge(base + 288);
        habilitar = 4'hF;

        e_rst = base + 308;
        wait_edge(e_rst);
        #1 reset = 1'b0;
        push_one(e_rst + 1, 4'hF, 8'hFF, 1'b0);
        push_one(e_rst + 2, 4'hF, 8'hFF, 1'b0);
        wait_edge(e_rst + 2);
        #1 reset = 1'b1;
        base = e_rst + 2;
        push_frame(base, 0, glifos[0], 4'hF, 32);

        wait_edge(base + 34);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
